serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new addition; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A; captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B; captured on an accepted start.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in; captured on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result register; holds its value until the next accepted start.
REQ-011 The block SHALL have port cout, output, 1 bit: final carry-out; held like sum.

Function
REQ-012 The block SHALL add a + b + cin bit-serially, LSB first, one bit per cycle, through a single one-bit full adder.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE SHALL go to RUN when start=1: capture a, b and cin into shift/carry registers, clear the bit counter to 0 and clear sum.
REQ-015 In RUN, each cycle SHALL shift in one sum bit (MSB-first into sum, so that bit i lands at sum[i] after WIDTH shifts), update the carry register and increment the counter.
REQ-016 RUN SHALL go to DONE on the cycle in which counter == WIDTH-1 is processed; the total RUN duration SHALL be exactly WIDTH cycles.
REQ-017 DONE SHALL last one cycle with done=1 and cout = final carry, then return to IDLE unconditionally.
REQ-018 The latency from the accepting start edge to done=1 SHALL be WIDTH+1 cycles; the minimum issue interval SHALL be WIDTH+2 cycles.
REQ-019 start asserted in RUN or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-020 Changes on a, b or cin after capture SHALL NOT affect the result in progress.
REQ-021 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; the two SHALL never be high together.
REQ-022 The result SHALL equal (a + b + cin) mod 2^WIDTH, and cout SHALL equal bit WIDTH of the full sum.

Reset
REQ-023 While rst=1 the block SHALL force the state to IDLE and set busy=0, done=0, sum=0, cout=0, counter=0 and carry=0; rst SHALL take priority over start.
REQ-024 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 With macro SERIAL_ADD_OVF_EN defined, the block SHALL add output ovf (1 bit), the signed two's-complement overflow, set to carry-into-MSB XOR carry-out-of-MSB, registered in DONE, held like cout, and reset to 0.
REQ-026 Without SERIAL_ADD_OVF_EN, the ovf port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constant SERIAL_ADD_WIDTH_DEF = 8.
REQ-028 The block SHALL instantiate exactly one one-bit full adder, fa (the team's existing half-adder-based cell, ports a, b, cin, sum, carry); it SHALL NOT contain a parallel adder.

Verification
REQ-029 Scenario: WIDTH=8, a=0x0F, b=0x01, cin=0, start for 1 cycle -> busy high for 8 cycles, done at cycle 9, sum=0x10, cout=0.
REQ-030 Scenario: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with SERIAL_ADD_OVF_EN, ovf=0.
REQ-031 Scenario: a=0x7F, b=0x01, cin=0 with SERIAL_ADD_OVF_EN -> sum=0x80, cout=0, ovf=1.
REQ-032 Scenario: a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-033 Scenario: start held high continuously while a/b change every cycle -> operations are accepted only in IDLE, exactly every 10 cycles, each result matching the operands present at its accepting edge.
REQ-034 Scenario: rst asserted at RUN cycle 4 -> no done pulse, all outputs 0 the next cycle; a following start with a=3, b=4 -> sum=0x07.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

   localparam int SERIAL_ADD_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder assembled from two half adders and an OR of their carries.
module serial_add_ctrl_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic carry
);

   logic w_ha0_s;
   logic w_ha0_c;
   logic w_ha1_c;

   assign w_ha0_s = a ^ b;
   assign w_ha0_c = a & b;
   assign sum     = w_ha0_s ^ cin;
   assign w_ha1_c = w_ha0_s & cin;
   assign carry   = w_ha0_c | w_ha1_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: LSB-first through one full adder, WIDTH cycles per operation.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic [CNT_W-1:0] r_cnt;
   logic             w_last;
   logic             w_fa_s;
   logic             w_fa_c;
`ifdef SERIAL_ADD_OVF_EN
   logic             r_ovf;
`endif

   serial_add_ctrl_fa fa (
      .a     (r_a[0]),
      .b     (r_b[0]),
      .cin   (r_carry),
      .sum   (w_fa_s),
      .carry (w_fa_c)
   );

   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            done   = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                  r_ovf   <= 1'b0;
`endif
               end
            end
            RUN: begin
               // New bit enters at the MSB so bit i reaches sum[i] after WIDTH shifts.
               r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_fa_c;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_cout <= w_fa_c;
`ifdef SERIAL_ADD_OVF_EN
                  // r_carry is the carry into the MSB on this last cycle.
                  r_ovf  <= r_carry ^ w_fa_c;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl; honours SERIAL_ADD_OVF_EN when defined.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, need %0h", tag, act, req);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      exp_t       m;
      logic [W:0] full;
      full = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
      m.s  = full[W-1:0];
      m.c  = full[W];
      m.o  = (ta[W-1] == tb_v[W-1]) && (full[W-1] != ta[W-1]);
      return m;
   endfunction

   // Result monitor: every done pulse retires the oldest expected result
   always @(negedge clk) begin
      if (done) begin
         chk("busy_done_excl", {63'd0, busy}, 64'd0);
         if (sb.size() == 0) begin
            chk("spurious_done", {63'd0, done}, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sum", {56'd0, sum}, {56'd0, mon_e.s});
            chk("cout", {63'd0, cout}, {63'd0, mon_e.c});
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf", {63'd0, ovf}, {63'd0, mon_e.o});
`endif
         end
      end
   end

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
      exp_t e;
      int   lat;
      int   nb;
      e = model(ta, tb_v, tc);
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
      lat = 1;
      nb  = 0;
      while (!done && lat < 3 * W) begin
         if (busy) nb++;
         @(negedge clk);
         lat++;
      end
      chk("latency", 64'(lat), 64'(W + 1));
      chk("busy_cycles", 64'(nb), 64'(W));
      @(negedge clk);
      chk("sum_hold", {56'd0, sum}, {56'd0, e.s});
      chk("cout_hold", {63'd0, cout}, {63'd0, e.c});
      chk("idle_busy", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_sum", {56'd0, sum}, 64'd0);
      chk("rst_cout", {63'd0, cout}, 64'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
      rst = 1'b0;

      // Directed corner operands
      run_op(8'h0F, 8'h01, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'h7F, 8'h01, 1'b0);
      run_op(8'hFF, 8'hFF, 1'b1);
      run_op(8'h80, 8'h80, 1'b0);
      run_op(8'h00, 8'h00, 1'b1);
      for (int i = 0; i < 6; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom));
      end

      // start held high with operands changing every cycle
      for (int j = 0; j < 40; j++) begin
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
         if (j % 10 == 0) sb.push_back(model(a, b, cin));
         @(negedge clk);
         chk("cont_busy", {63'd0, busy}, {63'd0, (j % 10) < 8});
         chk("cont_done", {63'd0, done}, {63'd0, (j % 10) == 8});
      end
      start = 1'b0;
      @(negedge clk);

      // Reset during RUN aborts without a done pulse
      a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_sum", {56'd0, sum}, 64'd0);
      chk("abort_cout", {63'd0, cout}, 64'd0);
      rst = 1'b0;
      run_op(8'h03, 8'h04, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
